// File: rtl/uart_rom_loader.sv
// Boot loader: receives a length-prefixed CHIP-8 image over 8N1 UART and
// writes it into program memory, holding the CPU until the image is complete.
module uart_rom_loader #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter logic [11:0] LOAD_BASE    = 12'h200,
  parameter int unsigned MAX_LEN      = 3584
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        mem_write,
  output logic [11:0] mem_write_addr,
  output logic [7:0]  mem_write_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [11:0] byte_count
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0] MAX_LEN_L = 12'(MAX_LEN);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_HDR_HI, LD_HDR_LO, LD_DATA, LD_DONE, LD_ERROR} ld_state_t;

  logic rx_meta, rx_s;

  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       rx_byte, rx_byte_n;
  logic             byte_valid_c, framing_err_c;

  ld_state_t   ld_state, ld_state_n;
  logic [11:0] len, len_n;
  logic [11:0] hdr_len_c;
  logic [11:0] byte_count_n;
  logic        mem_write_n;
  logic [11:0] mem_write_addr_n;
  logic [7:0]  mem_write_data_n;
  logic        cpu_hold_n, load_done_n, load_error_n;

  // Two-flop synchroniser for the asynchronous serial line (idles high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // RX FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      rx_state <= rx_state_n;
      clk_cnt  <= clk_cnt_n;
      bit_idx  <= bit_idx_n;
      rx_byte  <= rx_byte_n;
    end
  end

  // RX FSM: mid-bit sampling, start glitch rejection, stop-bit check
  always_comb begin
    rx_state_n    = rx_state;
    clk_cnt_n     = clk_cnt;
    bit_idx_n     = bit_idx;
    rx_byte_n     = rx_byte;
    byte_valid_c  = 1'b0;
    framing_err_c = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        clk_cnt_n = '0;
        bit_idx_n = '0;
        if (!rx_s) rx_state_n = RX_START;
      end
      RX_START: begin
        if (clk_cnt == HALF_END) begin
          clk_cnt_n  = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt == BIT_END) begin
          clk_cnt_n = '0;
          rx_byte_n = {rx_s, rx_byte[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_n = RX_STOP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt == BIT_END) begin
          clk_cnt_n     = '0;
          byte_valid_c  = rx_s;
          framing_err_c = !rx_s;
          rx_state_n    = RX_IDLE;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign hdr_len_c = {len[11:8], rx_byte};

  // Loader FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state       <= LD_HDR_HI;
      len            <= '0;
      byte_count     <= '0;
      mem_write      <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      cpu_hold       <= 1'b1;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      ld_state       <= ld_state_n;
      len            <= len_n;
      byte_count     <= byte_count_n;
      mem_write      <= mem_write_n;
      mem_write_addr <= mem_write_addr_n;
      mem_write_data <= mem_write_data_n;
      cpu_hold       <= cpu_hold_n;
      load_done      <= load_done_n;
      load_error     <= load_error_n;
    end
  end

  // Loader FSM: header parse, payload writes, sticky done/error flags
  always_comb begin
    ld_state_n       = ld_state;
    len_n            = len;
    byte_count_n     = byte_count;
    mem_write_n      = 1'b0;
    mem_write_addr_n = mem_write_addr;
    mem_write_data_n = mem_write_data;
    load_done_n      = load_done | (ld_state == LD_DONE);
    load_error_n     = load_error | (ld_state == LD_ERROR);
    cpu_hold_n       = cpu_hold & (ld_state != LD_DONE);
    case (ld_state)
      LD_HDR_HI: begin
        if (framing_err_c) begin
          ld_state_n = LD_ERROR;
        end else if (byte_valid_c) begin
          len_n      = {rx_byte[3:0], 8'h00};
          ld_state_n = (rx_byte[7:4] != 4'h0) ? LD_ERROR : LD_HDR_LO;
        end
      end
      LD_HDR_LO: begin
        if (framing_err_c) begin
          ld_state_n = LD_ERROR;
        end else if (byte_valid_c) begin
          len_n = hdr_len_c;
          if (hdr_len_c == 12'd0 || hdr_len_c > MAX_LEN_L) ld_state_n = LD_ERROR;
          else ld_state_n = LD_DATA;
        end
      end
      LD_DATA: begin
        if (framing_err_c) begin
          ld_state_n = LD_ERROR;
        end else if (byte_valid_c) begin
          mem_write_n      = 1'b1;
          mem_write_addr_n = LOAD_BASE + byte_count;
          mem_write_data_n = rx_byte;
          byte_count_n     = byte_count + 12'd1;
          if (byte_count + 12'd1 == len) ld_state_n = LD_DONE;
        end
      end
      LD_DONE:  ld_state_n = LD_DONE;
      LD_ERROR: ld_state_n = LD_ERROR;
      default:  ld_state_n = LD_ERROR;
    endcase
  end

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader: main DUT at the default memory map,
// second DUT with a small window ending at 0xFFF to exercise the top boundary.
module tb_uart_rom_loader;

  localparam int unsigned CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic rx2 = 1'b1;

  logic        mem_write, cpu_hold, load_done, load_error;
  logic [11:0] mem_write_addr, byte_count;
  logic [7:0]  mem_write_data;

  logic        mem_write2, cpu_hold2, load_done2, load_error2;
  logic [11:0] mem_write_addr2, byte_count2;
  logic [7:0]  mem_write_data2;

  int checks = 0;
  int errors = 0;

  logic [19:0] wq[$];
  int   cyc = 0;
  int   last_w = -1;
  int   done_cyc = -1;
  int   b2b = 0;
  logic prev_w = 1'b0;
  logic prev_done = 1'b0;
  int   w2_cnt = 0;
  logic [11:0] w2_last = '0;

  uart_rom_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error), .byte_count(byte_count)
  );

  uart_rom_loader #(.CLKS_PER_BIT(CPB), .LOAD_BASE(12'hFF0), .MAX_LEN(16)) dut2 (
    .clk(clk), .rst(rst), .uart_rx(rx2),
    .mem_write(mem_write2), .mem_write_addr(mem_write_addr2),
    .mem_write_data(mem_write_data2), .cpu_hold(cpu_hold2),
    .load_done(load_done2), .load_error(load_error2), .byte_count(byte_count2)
  );

  always #5 clk = ~clk;

  // Write/done monitor sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_write) begin
      wq.push_back({mem_write_addr, mem_write_data});
      last_w = cyc;
      if (prev_w) b2b = b2b + 1;
    end
    if (load_done && !prev_done) done_cyc = cyc;
    prev_w    = mem_write;
    prev_done = load_done;
    if (mem_write2) begin
      w2_cnt  = w2_cnt + 1;
      w2_last = mem_write_addr2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit l2, input logic v);
    if (l2) rx2 = v;
    else uart_rx = v;
  endtask

  task automatic send_byte(input bit l2, input logic [7:0] b, input logic stop_bit);
    drive(l2, 1'b0);
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(l2, b[i]);
      repeat (CPB) @(posedge clk);
    end
    drive(l2, stop_bit);
    repeat (CPB) @(posedge clk);
    drive(l2, 1'b1);
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    wq.delete();
    done_cyc = -1;
    last_w = -1;
    w2_cnt = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_addr", 32'(mem_write_addr), 32'd0);
    check("rst_data", 32'(mem_write_data), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    check("rst_count", 32'(byte_count), 32'd0);
    do_reset();

    // Basic 3-byte load
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h03, 1'b1);
    send_byte(0, 8'hA2, 1'b1);
    send_byte(0, 8'h1E, 1'b1);
    check("mid_hold", 32'(cpu_hold), 32'd1);
    check("mid_done", 32'(load_done), 32'd0);
    send_byte(0, 8'h60, 1'b1);
    check("basic_nwrites", 32'(wq.size()), 32'd3);
    check("basic_w0", 32'(wq[0]), 32'h200A2);
    check("basic_w1", 32'(wq[1]), 32'h2011E);
    check("basic_w2", 32'(wq[2]), 32'h20260);
    check("basic_done", 32'(load_done), 32'd1);
    check("basic_hold", 32'(cpu_hold), 32'd0);
    check("basic_count", 32'(byte_count), 32'd3);
    check("basic_error", 32'(load_error), 32'd0);
    check("basic_done_lat", 32'(done_cyc), 32'(last_w + 1));

    // Traffic after done is ignored, including a bad stop bit
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    send_byte(0, 8'h33, 1'b1);
    send_byte(0, 8'h44, 1'b0);
    check("post_nwrites", 32'(wq.size()), 32'd3);
    check("post_done", 32'(load_done), 32'd1);
    check("post_error", 32'(load_error), 32'd0);
    check("post_count", 32'(byte_count), 32'd3);

    // Zero length header
    do_reset();
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h55, 1'b1);
    check("len0_error", 32'(load_error), 32'd1);
    check("len0_hold", 32'(cpu_hold), 32'd1);
    check("len0_nwrites", 32'(wq.size()), 32'd0);

    // Length one above the maximum
    do_reset();
    send_byte(0, 8'h0E, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h55, 1'b1);
    check("len3585_error", 32'(load_error), 32'd1);
    check("len3585_hold", 32'(cpu_hold), 32'd1);
    check("len3585_nwrites", 32'(wq.size()), 32'd0);

    // Maximum length accepted; first writes start at the base
    do_reset();
    send_byte(0, 8'h0E, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h5A, 1'b1);
    send_byte(0, 8'hA5, 1'b1);
    check("len3584_error", 32'(load_error), 32'd0);
    check("len3584_nwrites", 32'(wq.size()), 32'd2);
    check("len3584_w0", 32'(wq[0]), 32'h2005A);
    check("len3584_w1", 32'(wq[1]), 32'h201A5);
    check("len3584_done", 32'(load_done), 32'd0);

    // Window that ends exactly at 0xFFF; one-too-long header rejected
    do_reset();
    send_byte(1, 8'h00, 1'b1);
    send_byte(1, 8'h10, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(1, 8'(i), 1'b1);
    check("top_nwrites", 32'(w2_cnt), 32'd16);
    check("top_last_addr", 32'(w2_last), 32'hFFF);
    check("top_done", 32'(load_done2), 32'd1);
    check("top_error", 32'(load_error2), 32'd0);
    do_reset();
    send_byte(1, 8'h00, 1'b1);
    send_byte(1, 8'h11, 1'b1);
    check("top_over_error", 32'(load_error2), 32'd1);

    // Framing error on second payload byte
    do_reset();
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h04, 1'b1);
    send_byte(0, 8'hC3, 1'b1);
    send_byte(0, 8'h3C, 1'b0);
    send_byte(0, 8'h77, 1'b1);
    send_byte(0, 8'h88, 1'b1);
    check("frm_nwrites", 32'(wq.size()), 32'd1);
    check("frm_w0", 32'(wq[0]), 32'h200C3);
    check("frm_error", 32'(load_error), 32'd1);
    check("frm_hold", 32'(cpu_hold), 32'd1);
    check("frm_done", 32'(load_done), 32'd0);

    // Short start-bit glitch, then a normal load
    do_reset();
    uart_rx = 1'b0;
    repeat (CPB / 2 - 2) @(posedge clk);
    uart_rx = 1'b1;
    repeat (4 * CPB) @(posedge clk);
    #1;
    check("glitch_rx_idle", 32'(dut.rx_state), 32'd0);
    check("glitch_ld_hdr", 32'(dut.ld_state), 32'd0);
    check("glitch_nwrites", 32'(wq.size()), 32'd0);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    check("glitch_w0", 32'(wq[0]), 32'h20011);
    check("glitch_w1", 32'(wq[1]), 32'h20122);
    check("glitch_done", 32'(load_done), 32'd1);

    // Reset in the middle of a load, then a full reload
    do_reset();
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h05, 1'b1);
    send_byte(0, 8'hF0, 1'b1);
    send_byte(0, 8'hF1, 1'b1);
    check("pre_rst_count", 32'(byte_count), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("async_hold", 32'(cpu_hold), 32'd1);
    check("async_count", 32'(byte_count), 32'd0);
    check("async_addr", 32'(mem_write_addr), 32'd0);
    check("async_data", 32'(mem_write_data), 32'd0);
    do_reset();
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h05, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(0, 8'(8'h30 + i), 1'b1);
    check("reload_nwrites", 32'(wq.size()), 32'd5);
    check("reload_w0", 32'(wq[0]), 32'h20030);
    check("reload_w4", 32'(wq[4]), 32'h20434);
    check("reload_done", 32'(load_done), 32'd1);
    check("reload_count", 32'(byte_count), 32'd5);

    check("no_back_to_back", 32'(b2b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rom_loader.md
Name: uart_rom_loader

Overview:
Boot-time program loader upstream of the chip8 memory write port and CPU. Receives a CHIP-8 program over UART (8N1), using a 2-byte big-endian length header followed by payload bytes. Writes each payload byte into memory starting at LOAD_BASE. Holds the CPU in reset-hold until the load completes.

Parameters:
CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200); must be >= 4
LOAD_BASE, 12'h200, memory address of the first payload byte
MAX_LEN, 3584, largest accepted payload length (LOAD_BASE + MAX_LEN - 1 = 12'hFFF)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
uart_rx  input  1  asynchronous serial input; idles high
mem_write  output  1  one-cycle write strobe to the memory write port
mem_write_addr  output  12  write address; valid while mem_write=1
mem_write_data  output  8  write data; valid while mem_write=1
cpu_hold  output  1  1 = CPU must not fetch/execute
load_done  output  1  sticky; high when the full payload has been written
load_error  output  1  sticky; high on framing error or bad length
byte_count  output  12  number of payload bytes written so far

Behaviour:
- Reset (async, rst=1) values: cpu_hold=1, mem_write=0, mem_write_addr=0, mem_write_data=0, load_done=0, load_error=0, byte_count=0. The rx synchroniser flops reset to 1. Both FSMs reset to their initial states.
- uart_rx passes through a 2-flop synchroniser; all sampling uses the synchronised value rx_s.
- RX FSM:
  - IDLE: rx_s=0 -> START; bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then resample. If still 0 -> DATA; if 1 -> IDLE (glitch rejected, no byte produced).
  - DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first, shifted into the rx byte; after bit 7 -> STOP.
  - STOP: sample after CLKS_PER_BIT. If 1 -> one-cycle internal byte_valid pulse, then IDLE. If 0 -> framing_err pulse, then IDLE.
- Loader FSM:
  - HDR_HI: on byte_valid, len[11:0] takes byte[3:0] as its high nibble; byte[7:4] != 0 -> ERROR; else -> HDR_LO.
  - HDR_LO: on byte_valid, len[7:0]=byte. Final len==0 or len>MAX_LEN -> ERROR; else -> DATA.
  - DATA: on byte_valid, in the next cycle drive mem_write=1, mem_write_addr=LOAD_BASE+byte_count, mem_write_data=byte; byte_count increments in that same cycle. When the incremented byte_count == len -> DONE.
  - DONE: load_done=1, cpu_hold=0 from the cycle after the last mem_write. Further UART bytes and framing errors are ignored; no writes occur.
  - ERROR: load_error=1, cpu_hold stays 1, no writes occur. Exit only via rst.
- framing_err in HDR_HI, HDR_LO or DATA -> ERROR. framing_err in DONE is ignored.
- mem_write is never high for two consecutive cycles; minimum spacing is one UART frame.
- Address arithmetic is 12-bit. No wrap is possible with the parameter constraint LOAD_BASE+MAX_LEN <= 4096.
- rst mid-load: all state is discarded, cpu_hold returns to 1 immediately (asynchronously), and the loader restarts at HDR_HI. Memory contents already written are not cleared.
- Latency: mem_write is asserted 1 cycle after the stop-bit sample of the corresponding byte.

Test Plan:
- Send 0x00,0x03,0xA2,0x1E,0x60 at CLKS_PER_BIT=8 -> three mem_write pulses: (0x200,0xA2), (0x201,0x1E), (0x202,0x60); load_done=1, cpu_hold=0 one cycle after the third pulse; byte_count=3; load_error=0.
- Header 0x00,0x00 -> load_error=1, cpu_hold=1, no mem_write. Header 0x0E,0x01 (3585) -> same result. Header 0x0E,0x00 (3584) is accepted and its last write goes to address 0xFFF.
- Stop bit driven low during the second payload byte of a 4-byte load -> exactly 1 mem_write, then load_error=1, cpu_hold=1; later valid bytes produce no writes.
- Low pulse on uart_rx of CLKS_PER_BIT/2-2 cycles while idle -> no byte produced, FSM states unchanged; a following valid load completes normally.
- Assert rst after 2 of 5 payload bytes -> outputs return to reset values immediately; a new complete 5-byte load writes starting at 0x200 and sets load_done.
- After load_done, send 3 extra bytes plus one bad stop bit -> no mem_write; load_done stays 1, load_error stays 0, byte_count unchanged.
